// File: rtl/dcache_axi_master.sv
// dcache_axi_master: AXI4 master for the data cache serving word reads/writes and INCR line fill/writeback bursts.
module dcache_axi_master #(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         BURST_LEN  = 4,
    parameter logic [3:0] CACHE_ATTR = 4'b0011
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                wb_rd,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_last,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [3:0]          awcache,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [3:0]          arcache,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);
    localparam int SB = DATA_W / 8;
    localparam int SZ = $clog2(SB);
    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, FIN} state_t;
    state_t state, state_n;

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SB-1:0]     wstrb_q;
    logic [CW-1:0]     cnt;
    logic              err_q, ld_q, wb_rd_q;
    logic              line, last, acc, rhs, whs;

    assign line      = op_q[1];
    assign last      = cnt == (line ? CW'(BURST_LEN - 1) : '0);
    assign req_ready = rst_n && state == IDLE;
    assign acc       = req_valid && req_ready;
    assign rhs       = rvalid && rready;
    assign whs       = wvalid && wready;

    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign awlen   = line ? 8'(BURST_LEN - 1) : 8'd0;
    assign arlen   = awlen;
    assign awsize  = 3'(SZ);
    assign arsize  = 3'(SZ);
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign awcache = CACHE_ATTR;
    assign arcache = CACHE_ATTR;
    assign arvalid = state == RADDR;
    assign rready  = state == RDATA;
    assign awvalid = state == WADDR;
    assign bready  = state == WRESP;
    // Writeback data is usable straight off wb_data in the cycle after wb_rd, then held from wdata_q
    assign wdata   = ld_q ? wb_data : wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = state == WDATA && !wb_rd_q;
    assign wlast   = wvalid && last;
    assign wb_rd   = wb_rd_q;
    assign done    = state == FIN;
    assign err     = done && err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (acc) state_n = req_op[0] ? WADDR : RADDR;
            RADDR:   if (arready) state_n = RDATA;
            RDATA:   if (rhs && last) state_n = FIN;
            WADDR:   if (awready) state_n = WDATA;
            WDATA:   if (whs && last) state_n = WRESP;
            WRESP:   if (bvalid) state_n = FIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            ld_q     <= 1'b0;
            wb_rd_q  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            wb_rd_q  <= 1'b0;
            ld_q     <= wb_rd_q;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (ld_q) wdata_q <= wb_data;
            if (acc) begin
                op_q    <= req_op;
                addr_q  <= req_op[1] ? req_addr & ~ADDR_W'(BURST_LEN * SB - 1) : req_addr & ~ADDR_W'(SB - 1);
                wdata_q <= req_wdata;
                wstrb_q <= req_op[1] ? '1 : req_wstrb;
                cnt     <= '0;
                wb_rd_q <= req_op == 2'b11;
            end
            if (rhs) begin
                rd_data  <= rdata;
                rd_valid <= 1'b1;
                rd_last  <= last;
                cnt      <= cnt + CW'(1);
                if (rresp != 2'b00 || rlast != last) err_q <= 1'b1;
            end
            if (whs) begin
                cnt     <= cnt + CW'(1);
                wb_rd_q <= line && !last;
            end
            if (bvalid && bready && bresp != 2'b00) err_q <= 1'b1;
            if (state == FIN) begin
                err_q <= 1'b0;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dcache_axi_master.sv
// tb_dcache_axi_master: table-driven and randomized checks of dcache_axi_master against a transaction-level AXI slave and model.
module tb_dcache_axi_master;
    localparam int AW = 32, DW = 32, BL = 4, SB = DW / 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready;
    logic [1:0] req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SB-1:0] req_wstrb = '0;
    logic [DW-1:0] wb_data = '0, rd_data;
    logic wb_rd, rd_valid, rd_last, done, err;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst;
    logic [3:0] awcache, arcache;
    logic awvalid, arvalid, awready = 1'b0, arready = 1'b0;
    logic [DW-1:0] wdata;
    logic [SB-1:0] wstrb;
    logic wlast, wvalid, wready = 1'b0;
    logic [1:0] bresp = '0;
    logic bvalid = 1'b0, bready;
    logic [DW-1:0] rdata = '0;
    logic [1:0] rresp = '0;
    logic rlast = 1'b0, rvalid = 1'b0, rready;

    dcache_axi_master #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .CACHE_ATTR(4'b0011)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .wb_data(wb_data),
        .wb_rd(wb_rd), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .done(done), .err(err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awcache(awcache),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arcache(arcache),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op; logic [31:0] addr, wdata; logic [3:0] wstrb; logic [31:0] base;
        int rlast_at, bad_beat; logic [1:0] bad_resp, bresp; int awd, wmode;
        logic [31:0] ea; logic [7:0] el; logic ee;
    } vec_t;
    typedef struct packed {logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [3:0] c;} ax_t;
    typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} wbeat_t;
    typedef struct packed {logic [31:0] d; logic l;} rbeat_t;

    ax_t ar_q[$], aw_q[$];
    wbeat_t w_q[$];
    rbeat_t rd_q[$];
    logic done_q[$];
    int total = 0, bad = 0, aw_vc = 0, wb_cnt = 0, stab = 0, wb_idx = 0;
    logic [31:0] wb_base = '0;
    bit rnd = 1'b0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Passive monitor: handshakes, pulses and valid/data stability while a channel is stalled
    initial begin
        logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
        logic [31:0] p_ara, p_awa;
        logic [36:0] p_w;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_ara = 0; p_awa = 0; p_w = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (p_arv && !p_arr && (!arvalid || araddr != p_ara)) stab++;
                if (p_awv && !p_awr && (!awvalid || awaddr != p_awa)) stab++;
                if (p_wv && !p_wr && (!wvalid || {wdata, wstrb, wlast} != p_w)) stab++;
                if ((err && !done) || (done && req_ready)) stab++;
            end
            if (arvalid && arready) ar_q.push_back({araddr, arlen, arsize, arburst, arcache});
            if (awvalid && awready) aw_q.push_back({awaddr, awlen, awsize, awburst, awcache});
            if (awvalid) aw_vc++;
            if (wvalid && wready) w_q.push_back({wdata, wstrb, wlast});
            if (wb_rd) wb_cnt++;
            if (rd_valid) rd_q.push_back({rd_data, rd_last});
            if (done) done_q.push_back(err);
            p_arv = arvalid; p_arr = arready; p_ara = araddr;
            p_awv = awvalid; p_awr = awready; p_awa = awaddr;
            p_wv = wvalid; p_wr = wready; p_w = {wdata, wstrb, wlast};
        end
    end

    // Writeback source: data valid only in the cycle after wb_rd, junk otherwise
    initial begin
        logic p;
        forever begin
            @(negedge clk);
            p = wb_rd;
            @(posedge clk);
            #1;
            if (p) begin
                wb_data = wb_base + 32'(wb_idx);
                wb_idx++;
            end else wb_data = $urandom;
        end
    end

    function automatic vec_t mk(logic [1:0] op, logic [31:0] addr, logic [31:0] wd, logic [3:0] ws,
                                logic [31:0] base, int rl, int bb, logic [1:0] br, logic [1:0] bs,
                                int awd, int wm, logic [31:0] ea, logic [7:0] el, logic ee);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wd; v.wstrb = ws; v.base = base; v.rlast_at = rl;
        v.bad_beat = bb; v.bad_resp = br; v.bresp = bs; v.awd = awd; v.wmode = wm;
        v.ea = ea; v.el = el; v.ee = ee;
        return v;
    endfunction

    function automatic vec_t model(input vec_t v);
        int n = v.op[1] ? BL : 1;
        int lb = v.op[1] ? BL * SB : SB;
        v.ea = 32'((v.addr / 32'(lb)) * 32'(lb));
        v.el = 8'(n - 1);
        v.ee = v.op[0] ? (v.bresp != 2'b00) : ((v.bad_beat >= 0 && v.bad_resp != 2'b00) || v.rlast_at != n - 1);
        return v;
    endfunction

    task automatic send_req(input vec_t v);
        bit ok = 0;
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready;
            step;
        end
        req_valid = 1'b0; req_op = 2'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        if (!ok) chk("req_timeout", 128'(0), 128'(1));
    endtask

    task automatic slave_read(input vec_t v, input int n);
        bit ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = arvalid;
        end
        if (!ok) begin
            chk("ar_timeout", 128'(0), 128'(1));
            return;
        end
        step;
        repeat (rnd ? $urandom_range(0, 3) : 0) step;
        arready = 1'b1;
        @(negedge clk);
        step;
        arready = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (rnd ? $urandom_range(0, 2) : 0) step;
            rvalid = 1'b1; rdata = v.base + 32'(i); rlast = (i == v.rlast_at);
            rresp = (i == v.bad_beat) ? v.bad_resp : 2'b00;
            ok = 0;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk);
                ok = rready;
                step;
            end
            rvalid = 1'b0; rlast = 1'b0; rdata = $urandom; rresp = 2'($urandom);
            if (!ok) begin
                chk("r_timeout", 128'(0), 128'(1));
                return;
            end
        end
    endtask

    task automatic slave_write(input vec_t v, input int n);
        bit ok = 0, tog = 0;
        int c = 1, beats = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = awvalid;
        end
        if (!ok) begin
            chk("aw_timeout", 128'(0), 128'(1));
            return;
        end
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step;
            awready = c >= v.awd;
            @(negedge clk);
            ok = awready && awvalid;
            c++;
        end
        step;
        awready = 1'b0;
        for (int k = 0; k < 200 && beats < n; k++) begin
            wready = v.wmode == 0 ? 1'b1 : v.wmode == 1 ? tog : 1'($urandom);
            tog = !tog;
            @(negedge clk);
            if (wvalid && wready) beats++;
            step;
        end
        wready = 1'b0;
        if (beats < n) begin
            chk("w_timeout", 128'(beats), 128'(n));
            return;
        end
        repeat (rnd ? $urandom_range(0, 2) : 0) step;
        bvalid = 1'b1; bresp = v.bresp;
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bready;
            step;
        end
        bvalid = 1'b0; bresp = 2'($urandom);
        if (!ok) chk("b_timeout", 128'(0), 128'(1));
    endtask

    task automatic run_txn(input vec_t v);
        int n = v.op[1] ? BL : 1;
        int a0 = aw_vc, w0 = wb_cnt, s0 = stab;
        bit ok = 0;
        ar_q.delete(); aw_q.delete(); w_q.delete(); rd_q.delete(); done_q.delete();
        wb_base = v.base; wb_idx = 0;
        fork
            send_req(v);
            if (v.op[0]) slave_write(v, n); else slave_read(v, n);
        join
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ok = done_q.size() != 0;
        end
        repeat (3) @(negedge clk);
        if (v.op[0]) begin
            chk("aw_count", 128'(aw_q.size()), 128'(1));
            chk("ar_none", 128'(ar_q.size() + rd_q.size()), 128'(0));
            if (aw_q.size() > 0) begin
                chk("awaddr", 128'(aw_q[0].a), 128'(v.ea));
                chk("awlen", 128'(aw_q[0].l), 128'(v.el));
                chk("aw_attr", 128'({aw_q[0].s, aw_q[0].b, aw_q[0].c}), 128'({3'd2, 2'b01, 4'b0011}));
            end
            chk("aw_valid_cycles", 128'(aw_vc - a0), 128'((v.awd < 1 ? 1 : v.awd) + 1));
            chk("w_beats", 128'(w_q.size()), 128'(n));
            for (int i = 0; i < n && i < w_q.size(); i++) begin
                chk("wdata", 128'(w_q[i].d), 128'(v.op[1] ? v.base + 32'(i) : v.wdata));
                chk("wstrb", 128'(w_q[i].s), 128'(v.op[1] ? 4'hF : v.wstrb));
                chk("wlast", 128'(w_q[i].l), 128'(i == n - 1));
            end
            chk("wb_rd_pulses", 128'(wb_cnt - w0), 128'(v.op[1] ? n : 0));
        end else begin
            chk("ar_count", 128'(ar_q.size()), 128'(1));
            chk("aw_none", 128'(aw_q.size() + w_q.size() + (wb_cnt - w0)), 128'(0));
            if (ar_q.size() > 0) begin
                chk("araddr", 128'(ar_q[0].a), 128'(v.ea));
                chk("arlen", 128'(ar_q[0].l), 128'(v.el));
                chk("ar_attr", 128'({ar_q[0].s, ar_q[0].b, ar_q[0].c}), 128'({3'd2, 2'b01, 4'b0011}));
            end
            chk("rd_beats", 128'(rd_q.size()), 128'(n));
            for (int i = 0; i < n && i < rd_q.size(); i++) begin
                chk("rd_data", 128'(rd_q[i].d), 128'(v.base + 32'(i)));
                chk("rd_last", 128'(rd_q[i].l), 128'(i == n - 1));
            end
        end
        chk("done_count", 128'(done_q.size()), 128'(1));
        if (done_q.size() > 0) chk("done_err", 128'(done_q[0]), 128'(v.ee));
        chk("protocol", 128'(stab - s0), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        tbl[0] = mk(2'b10, 32'h1004, 0, 0, 32'hA0, 3, -1, 0, 0, 0, 0, 32'h1000, 3, 0);
        tbl[1] = mk(2'b01, 32'h2008, 32'hDEADBEEF, 4'b0011, 0, 0, -1, 0, 0, 3, 0, 32'h2008, 0, 0);
        tbl[2] = mk(2'b11, 32'h3000, 0, 0, 32'h1, 0, -1, 0, 2'b10, 0, 1, 32'h3000, 3, 1);
        tbl[3] = mk(2'b10, 32'h401C, 0, 0, 32'hB0, 2, -1, 0, 0, 0, 0, 32'h4010, 3, 1);
        tbl[4] = mk(2'b00, 32'h5006, 0, 0, 32'hC0, 0, 0, 2'b11, 0, 0, 0, 32'h5004, 0, 1);
        tbl[5] = mk(2'b00, 32'h6000, 0, 0, 32'hD0, 0, -1, 0, 0, 0, 0, 32'h6000, 0, 0);
        tbl[6] = mk(2'b10, 32'h7FFC, 0, 0, 32'hE0, -1, -1, 0, 0, 0, 0, 32'h7FF0, 3, 1);
        tbl[7] = mk(2'b01, 32'h8003, 32'h12345678, 4'b1000, 0, 0, -1, 0, 2'b01, 1, 2, 32'h8000, 0, 1);
        tbl[8] = mk(2'b11, 32'h9018, 0, 0, 32'h100, 0, -1, 0, 0, 2, 2, 32'h9010, 3, 0);
        tbl[9] = mk(2'b10, 32'hA000, 0, 0, 32'hF0, 3, 2, 2'b10, 0, 0, 0, 32'hA000, 3, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 128'({req_ready, awvalid, wvalid, bready, arvalid, rready, rd_valid, rd_last, done, err, wb_rd}), 128'(0));
        chk("reset_fields", 128'({awaddr, araddr, awlen, arlen, wdata}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 128'(req_ready), 128'(1));
        step;

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset in the middle of a line fill, after two beats have been accepted
        rd_q.delete(); done_q.delete();
        v = mk(2'b10, 32'hB000, 0, 0, 0, 3, -1, 0, 0, 0, 0, 32'hB000, 3, 0);
        send_req(v);
        arready = 1'b1;
        @(negedge clk);
        chk("mr_arvalid", 128'(arvalid), 128'(1));
        step;
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h55;
        @(negedge clk);
        step;
        rdata = 32'h56;
        @(negedge clk);
        step;
        rdata = 32'h57; rst_n = 1'b0;
        step;
        @(negedge clk);
        chk("mr_rready", 128'({rready, req_ready, done}), 128'(0));
        step;
        rst_n = 1'b1; rlast = 1'b1;
        repeat (3) step;
        @(negedge clk);
        chk("mr_ignored", 128'({rready, req_ready}), 128'({1'b0, 1'b1}));
        step;
        rvalid = 1'b0; rlast = 1'b0;
        step;
        chk("mr_no_done", 128'(done_q.size()), 128'(0));
        chk("mr_rd_beats", 128'(rd_q.size()), 128'(2));
        if (rd_q.size() == 2) chk("mr_rd_data", 128'({rd_q[0].d, rd_q[1].d}), 128'({32'h55, 32'h56}));
        run_txn(mk(2'b00, 32'hC008, 0, 0, 32'h77, 0, -1, 0, 0, 0, 0, 32'hC008, 0, 0));

        rnd = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int n, r;
            v.op = 2'($urandom);
            n = v.op[1] ? BL : 1;
            v.addr = $urandom; v.wdata = $urandom; v.wstrb = 4'($urandom); v.base = $urandom;
            r = $urandom_range(0, 5);
            v.rlast_at = r == 0 ? -1 : r == 1 ? $urandom_range(0, n - 1) : n - 1;
            v.bad_beat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            v.bad_resp = 2'($urandom_range(1, 3));
            v.bresp = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            v.awd = $urandom_range(0, 3);
            v.wmode = 2;
            run_txn(model(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
